// File: rtl/gray_counter.sv
// gray_counter: free-running W-bit reflected-binary Gray code counter.
// A binary count B advances on every rising clock edge. The Gray code of
// the next count is registered alongside it, so the output comes straight
// from flops. This keeps it glitch-free and safe to sample from another
// clock domain.
module gray_counter #(
  parameter int W = 8
) (
  input  logic         reset,   // asynchronous, active-low
  input  logic         clock,
  output logic [W-1:0] out
);

  logic [W-1:0] b_q;
  logic [W-1:0] b_d;
  logic [W-1:0] g_q;
  logic [W-1:0] g_d;

  // Next binary count (wraps modulo 2^W) and its Gray encoding.
  always_comb begin
    b_d = b_q + W'(1);
    g_d = b_d ^ (b_d >> 1);
  end

  // Binary state and registered Gray output; reset clears both at once.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      b_q <= '0;
      g_q <= '0;
    end else begin
      b_q <= b_d;
      g_q <= g_d;
    end
  end

  assign out = g_q;

endmodule

// File: tb/tb_gray_counter.sv
// Scoreboard bench for gray_counter at W = 4, 1 and 8.
module tb_gray_counter;

  logic       clk = 1'b0;
  logic       rst4_n, rst1_n, rst8_n;
  logic [3:0] out4;
  logic [0:0] out1;
  logic [7:0] out8;

  int checks = 0;
  int errors = 0;

  logic [3:0] q4[$];
  logic [0:0] q1[$];
  logic [7:0] q8[$];

  logic       pc_en = 1'b0;
  logic [3:0] prev4 = 4'd0;
  logic       done4 = 1'b0, done1 = 1'b0, done8 = 1'b0;

  // Hand-written 4-bit Gray sequence for B = 0..15.
  logic [3:0] g4_tab [16] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010,
                              4'b0110, 4'b0111, 4'b0101, 4'b0100,
                              4'b1100, 4'b1101, 4'b1111, 4'b1110,
                              4'b1010, 4'b1011, 4'b1001, 4'b1000};
  logic [0:0] g1_tab [4]  = '{1'b1, 1'b0, 1'b1, 1'b0};

  always #5 clk = ~clk;

  gray_counter #(.W(4)) u4 (.reset(rst4_n), .clock(clk), .out(out4));
  gray_counter #(.W(1)) u1 (.reset(rst1_n), .clock(clk), .out(out1));
  gray_counter #(.W(8)) u8 (.reset(rst8_n), .clock(clk), .out(out8));

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] gray2bin8(input logic [7:0] g);
    logic [7:0] b;
    b[7] = g[7];
    for (int i = 6; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  // Monitors: pop expectations at the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (q4.size() > 0) begin
      logic [3:0] e;
      e = q4.pop_front();
      check("w4_seq", out4, e);
      if (pc_en) check("w4_onebit", $countones(prev4 ^ out4), 1);
      prev4 = out4;
    end
  end

  always @(negedge clk) begin
    if (q1.size() > 0) begin
      logic [0:0] e;
      e = q1.pop_front();
      check("w1_seq", out1, e);
    end
  end

  always @(negedge clk) begin
    if (q8.size() > 0) begin
      logic [7:0] e;
      e = q8.pop_front();
      check("w8_decode", gray2bin8(out8), e);
    end
  end

  // W = 4 stimulus: reset behaviour, full sequence, wrap, mid-count reset.
  initial begin : stim4
    rst4_n = 1'b0;
    repeat (2) begin @(posedge clk); q4.push_back(4'd0); end
    @(negedge clk); #2 rst4_n = 1'b1; pc_en = 1'b1;
    for (int i = 1; i <= 52; i++) begin
      @(posedge clk);
      q4.push_back(g4_tab[i % 16]);
    end
    @(negedge clk); #1 pc_en = 1'b0;
    check("w4_before_rst", out4, 4'b0110);
    rst4_n = 1'b0;
    #1 check("w4_rst_async", out4, 4'b0000);
    repeat (3) begin @(posedge clk); q4.push_back(4'd0); end
    @(negedge clk); #2 rst4_n = 1'b1;
    @(posedge clk); q4.push_back(4'b0001);
    @(posedge clk); q4.push_back(4'b0011);
    done4 = 1'b1;
  end

  // W = 1 stimulus: toggling output.
  initial begin : stim1
    rst1_n = 1'b0;
    repeat (2) begin @(posedge clk); q1.push_back(1'b0); end
    @(negedge clk); #2 rst1_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      q1.push_back(g1_tab[i]);
    end
    done1 = 1'b1;
  end

  // W = 8 stimulus: 600 edges of decode checks plus raw values at the wrap.
  initial begin : stim8
    rst8_n = 1'b0;
    @(posedge clk); q8.push_back(8'd0);
    @(negedge clk); #2 rst8_n = 1'b1;
    for (int i = 1; i <= 600; i++) begin
      @(posedge clk);
      q8.push_back(8'(i % 256));
      if (i == 255) begin #1 check("w8_edge255", out8, 8'b1000_0000); end
      if (i == 256) begin #1 check("w8_edge256", out8, 8'b0000_0000); end
    end
    done8 = 1'b1;
  end

  initial begin : watchdog
    #50000;
    $display("FAIL watchdog actual=timeout expected=completion");
    $fatal(1, "bench did not complete");
  end

  initial begin : finale
    wait (done4 && done1 && done8);
    repeat (2) @(negedge clk);
    #1;
    check("q4_drained", q4.size(), 0);
    check("q1_drained", q1.size(), 0);
    check("q8_drained", q8.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
